// File: rtl/relu3_stream_reader.sv
// Read-side sequencer for the ReLU3 activation memory: sweeps addresses 0..DEPTH-1,
// absorbs the one-cycle read latency and streams each activation with its index and last flag.
module relu3_stream_reader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int FIFO_D = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        mem_read_addr,
    input  logic signed [DATA_W-1:0] mem_data_out,
    output logic signed [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0]        out_index,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CNT_W = $clog2(FIFO_D + 3) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FIFO_LIM  = CNT_W'(FIFO_D);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t                   state_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [ADDR_W-1:0]        next_q;
    logic [ADDR_W-1:0]        issue_addr_d;
    logic [ADDR_W-1:0]        addr_p1;
    logic                     vld_p0;
    logic                     vld_p1;
    logic                     busy_q;
    logic                     done_q;
    logic signed [DATA_W-1:0] fifo_data_q [FIFO_D];
    logic [ADDR_W-1:0]        fifo_idx_q  [FIFO_D];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic [CNT_W-1:0]         occ_d;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;
    logic                     can_issue;
    logic                     issue;
    logic                     last_issue;

    // A slot freed by this cycle's pop may be reused by this cycle's issue.
    always_comb begin
        fifo_empty   = (count_q == '0);
        pop          = !fifo_empty && out_ready;
        push         = vld_p1;
        occ_d        = count_q + CNT_W'(vld_p0) + CNT_W'(vld_p1) - CNT_W'(pop);
        can_issue    = (occ_d < FIFO_LIM);
        issue_addr_d = (state_q == S_IDLE) ? '0 : next_q;
        issue        = ((state_q == S_IDLE) && start) || ((state_q == S_RUN) && can_issue);
        last_issue   = issue && (issue_addr_d == LAST_ADDR);
    end

    assign out_valid     = !fifo_empty;
    assign out_data      = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
    assign out_index     = fifo_empty ? '0 : fifo_idx_q[rd_ptr_q];
    assign out_last      = !fifo_empty && (fifo_idx_q[rd_ptr_q] == LAST_ADDR);
    assign mem_read_addr = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            next_q   <= '0;
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // stage p0: address issued; stage p1: memory sampling it; push on the next edge
            vld_p0 <= issue;
            vld_p1 <= vld_p0;
            if (issue) begin
                addr_q <= issue_addr_d;
                next_q <= issue_addr_d + ADDR_W'(1);
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= last_issue ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_issue) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && out_last) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Datapath storage carries no reset; occupancy is tracked by the control above.
    always_ff @(posedge clk) begin
        addr_p1 <= addr_q;
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_data_out;
            fifo_idx_q[wr_ptr_q]  <= addr_p1;
        end
    end

endmodule

// File: tb/tb_relu3_stream_reader.sv
// Directed bench for relu3_stream_reader: memory model, scoreboard queue, stall/latency/done checks.
module tb_relu3_stream_reader;
    localparam int DEPTH  = 64;
    localparam int FIFO_D = 4;

    typedef struct packed {
        logic [31:0] d;
        logic [15:0] i;
    } exp_t;

    logic               clk;
    logic               reset;
    logic               start;
    logic               busy;
    logic               done;
    logic [15:0]        mem_read_addr;
    logic signed [31:0] mem_data_out;
    logic signed [31:0] out_data;
    logic [15:0]        out_index;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    logic signed [31:0] mem [DEPTH];

    relu3_stream_reader #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(32), .FIFO_D(FIFO_D)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_read_addr(mem_read_addr), .mem_data_out(mem_data_out),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) mem_data_out <= mem[mem_read_addr[5:0]];

    int   total;
    int   bad;
    int   ncyc;
    int   done_cnt;
    int   sweep_xfers;
    int   last_xfer;
    int   prev_hs_cyc;
    bit   prev_stall;
    bit   prev_last_hs;
    bit   consec_en;
    bit   lead_en;
    logic [31:0] held_d;
    logic [15:0] held_i;
    logic        held_l;
    logic [31:0] seen5;
    logic [31:0] seen6;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic rdy, input logic st);
        bit   hs;
        exp_t e;
        @(negedge clk);
        out_ready = rdy;
        start     = st;
        ncyc++;
        if (!reset) begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", $unsigned(out_data), held_d);
                chk("stall_index", out_index, held_i);
                chk("stall_last", out_last, held_l);
            end
            if (busy) chk("addr_range", mem_read_addr < 16'(DEPTH), 1);
            if (lead_en) chk("addr_lead", int'(mem_read_addr) <= last_xfer + FIFO_D, 1);
            if (done) begin
                done_cnt++;
                chk("done_after_last", prev_last_hs, 1);
                chk("busy_with_done", busy, 0);
            end
            hs = out_valid && out_ready;
            if (hs) begin
                chk("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("data", $unsigned(out_data), e.d);
                    chk("index", out_index, e.i);
                    chk("last", out_last, e.i == 16'(DEPTH - 1));
                end
                if (consec_en && sweep_xfers > 0) chk("consecutive", ncyc - prev_hs_cyc, 1);
                if (out_index == 16'd5) seen5 = out_data;
                if (out_index == 16'd6) seen6 = out_data;
                prev_hs_cyc = ncyc;
                sweep_xfers++;
                last_xfer = int'(out_index);
            end
            prev_stall   = out_valid && !out_ready;
            prev_last_hs = hs && out_last;
            held_d = out_data;
            held_i = out_index;
            held_l = out_last;
        end else begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end
    endtask

    task automatic start_sweep(input logic rdy);
        exp_t e;
        for (int i = 0; i < DEPTH; i++) begin
            e.d = mem[i];
            e.i = 16'(i);
            exp_q.push_back(e);
        end
        sweep_xfers = 0;
        last_xfer   = -1;
        step(rdy, 1'b1);
        step(rdy, 1'b0);
        chk("busy_after_start", busy, 1);
        chk("first_addr", mem_read_addr, 0);
    endtask

    task automatic run_until_done(input bit toggle, input int max);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < max && done_cnt == d0; k++) step(toggle ? (k % 2 == 0) : 1'b1, 1'b0);
        chk("done_seen", done_cnt - d0, 1);
        chk("sweep_count", sweep_xfers, DEPTH);
        chk("queue_empty", exp_q.size(), 0);
        step(1'b1, 1'b0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, $unsigned(out_data), 0);
        chk({tag, "_index"}, out_index, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_addr"}, mem_read_addr, 0);
    endtask

    initial begin
        int d1;
        total = 0; bad = 0; ncyc = 0; done_cnt = 0;
        sweep_xfers = 0; last_xfer = -1; prev_hs_cyc = 0;
        prev_stall = 0; prev_last_hs = 0; consec_en = 0; lead_en = 0;
        seen5 = '0; seen6 = '0;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i - 32);

        repeat (3) step(1'b0, 1'b0);
        chk_all_zero("reset_state");
        reset = 1'b0;
        step(1'b1, 1'b0);

        // reset in the middle of a sweep
        start_sweep(1'b1);
        for (int k = 0; k < 200 && sweep_xfers < 20; k++) step(1'b1, 1'b0);
        chk("reached_20", sweep_xfers, 20);
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        step(1'b1, 1'b0);
        chk_all_zero("reset_next_cycle");
        reset = 1'b0;
        exp_q.delete();
        step(1'b1, 1'b0);

        // full-rate sweep, latency and consecutive transfers
        consec_en = 1'b1;
        start_sweep(1'b1);
        chk("valid_lat0", out_valid, 0);
        step(1'b1, 1'b0);
        chk("valid_lat1", out_valid, 0);
        step(1'b1, 1'b0);
        chk("valid_lat2", out_valid, 1);
        chk("first_index", out_index, 0);
        chk("first_data", $unsigned(out_data), 32'hFFFF_FFE0);
        run_until_done(1'b0, 200);
        consec_en = 1'b0;

        // alternating ready
        start_sweep(1'b1);
        lead_en = 1'b1;
        run_until_done(1'b1, 400);
        lead_en = 1'b0;

        // long stall right after start
        start_sweep(1'b0);
        repeat (30) step(1'b0, 1'b0);
        chk("halt_addr", mem_read_addr, FIFO_D - 1);
        chk("halt_valid", out_valid, 1);
        chk("halt_index", out_index, 0);
        chk("halt_no_xfer", sweep_xfers, 0);
        run_until_done(1'b0, 300);

        // start during a sweep is ignored
        start_sweep(1'b1);
        for (int k = 0; k < 200 && sweep_xfers < 10; k++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        run_until_done(1'b0, 300);
        d1 = done_cnt;
        repeat (5) step(1'b1, 1'b0);
        chk("single_done", done_cnt, d1);
        chk("no_resweep_busy", busy, 0);

        // signed extremes pass bit-exact
        mem[5] = 32'sh8000_0000;
        mem[6] = 32'sh7FFF_FFFF;
        start_sweep(1'b1);
        run_until_done(1'b0, 200);
        chk("neg_extreme", seen5, 32'h8000_0000);
        chk("pos_extreme", seen6, 32'h7FFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
